// File: rtl/adder_loader_pkg.sv
// Shared types and helpers for the adder operand loader.
package adder_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Number of IN_W-bit chunks per WIDTH-bit operand
    function automatic int unsigned CHUNKS_F(input int unsigned width, input int unsigned in_w);
        return width / in_w;
    endfunction

endpackage

// File: rtl/operand_chunk_reg.sv
// WIDTH-bit operand register written one IN_W-bit chunk at a time, with an
// optional whole-word load that a same-cycle chunk write overrides per chunk.
module operand_chunk_reg
    import adder_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IN_W  = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    we_i,
    input  logic [((CHUNKS_F(WIDTH, IN_W) > 1) ? $clog2(CHUNKS_F(WIDTH, IN_W)) : 1)-1:0] idx_i,
    input  logic [IN_W-1:0]                         din_i,
    input  logic                                    load_i,
    input  logic [WIDTH-1:0]                        load_val_i,
    output logic [WIDTH-1:0]                        q_o
);

    localparam int unsigned CHUNKS = CHUNKS_F(WIDTH, IN_W);
    localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [WIDTH-1:0] q_q, q_d;

    // Merge whole-word load and indexed chunk write
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end
        for (int unsigned c = 0; c < CHUNKS; c++) begin
            if (we_i && (idx_i == IDX_W'(c))) begin
                q_d[c*IN_W +: IN_W] = din_i;
            end
        end
    end

    // Operand storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/adder_operand_loader.sv
// Chunked operand feeder for the ripple-carry adder tile: assembles A and B
// from LSB-first chunks, issues them with valid/ready, and holds the returned
// sum until acknowledged.
// Optional macro ADDER_OPERAND_LOADER_CHAIN_EN: running-sum mode, where an
// acknowledged result becomes the next A and only B is loaded.
module adder_operand_loader
    import adder_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IN_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [IN_W-1:0]  din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic [WIDTH:0]   sum_in,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             busy,
    output logic             dropped
`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
    ,
    output logic             chain_carry
`endif
);

    localparam int unsigned CHUNKS   = CHUNKS_F(WIDTH, IN_W);
    localparam int unsigned LAST_CNT = 2 * CHUNKS - 1;
    localparam int unsigned CNT_W    = (2 * CHUNKS > 1) ? $clog2(2 * CHUNKS) : 1;
    localparam int unsigned IDX_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
    localparam int unsigned START_CNT = CHUNKS;
`else
    localparam int unsigned START_CNT = 0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, wr_cnt;
    logic               accept, transfer, ack_hold, drop, is_last;
    logic               we_a, we_b, load_a;
    logic [IDX_W-1:0]   idx_a, idx_b;
    logic [WIDTH-1:0]   load_a_val;
    logic               op_valid_q, op_valid_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;
    logic               dropped_q, dropped_d;
    logic [WIDTH:0]     result_q;
`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
    logic               chain_carry_q, chain_carry_d;
`endif

    // Per-state handshake qualification; clear masks every request
    always_comb begin
        accept   = 1'b0;
        transfer = 1'b0;
        ack_hold = 1'b0;
        drop     = 1'b0;
        if (!clear) begin
            case (state_q)
                IDLE, LOAD: accept = din_valid;
                ISSUE: begin
                    transfer = op_ready;
                    drop     = din_valid;
                end
                HOLD: begin
                    ack_hold = result_ack;
                    accept   = din_valid & result_ack;
                    drop     = din_valid & ~result_ack;
                end
                default: ;
            endcase
        end
        // A chunk taken with the ack starts a fresh operation
        wr_cnt  = (state_q == HOLD) ? CNT_W'(START_CNT) : cnt_q;
        is_last = (wr_cnt == CNT_W'(LAST_CNT));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: if (accept) state_d = is_last ? ISSUE : LOAD;
            ISSUE:      if (transfer) state_d = HOLD;
            HOLD: begin
                if (ack_hold) begin
                    state_d = accept ? (is_last ? ISSUE : LOAD) : IDLE;
                end
            end
            default:    state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // FSM outputs, chunk counter and operand write steering
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = is_last ? '0 : wr_cnt + CNT_W'(1);
        end else if (ack_hold) begin
            cnt_d = CNT_W'(START_CNT);
        end
        we_a           = accept && (wr_cnt < CNT_W'(CHUNKS));
        we_b           = accept && (wr_cnt >= CNT_W'(CHUNKS));
        idx_a          = IDX_W'(wr_cnt);
        idx_b          = IDX_W'(wr_cnt - CNT_W'(CHUNKS));
        op_valid_d     = (state_d == ISSUE);
        result_valid_d = (state_d == HOLD);
        busy_d         = (state_d != IDLE);
        dropped_d      = dropped_q | drop;
`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
        load_a         = ack_hold;
        load_a_val     = result_q[WIDTH-1:0];
        chain_carry_d  = clear ? 1'b0 : (chain_carry_q | (ack_hold & result_q[WIDTH]));
`else
        load_a         = 1'b0;
        load_a_val     = '0;
`endif
    end

    // Registered outputs, counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            op_valid_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            dropped_q      <= 1'b0;
            result_q       <= '0;
        end else begin
            cnt_q          <= cnt_d;
            op_valid_q     <= op_valid_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            dropped_q      <= dropped_d;
            if (transfer) begin
                result_q <= sum_in;
            end
        end
    end

`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
    // Sticky carry-out of the running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_carry_q <= 1'b0;
        end else begin
            chain_carry_q <= chain_carry_d;
        end
    end

    assign chain_carry = chain_carry_q;
`endif

    operand_chunk_reg #(.WIDTH(WIDTH), .IN_W(IN_W)) u_op_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we_a),
        .idx_i      (idx_a),
        .din_i      (din),
        .load_i     (load_a),
        .load_val_i (load_a_val),
        .q_o        (op_a)
    );

    operand_chunk_reg #(.WIDTH(WIDTH), .IN_W(IN_W)) u_op_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we_b),
        .idx_i      (idx_b),
        .din_i      (din),
        .load_i     (1'b0),
        .load_val_i ('0),
        .q_o        (op_b)
    );

    assign op_valid     = op_valid_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Bench for adder_operand_loader (WIDTH=4, IN_W=2) with a scoreboard of expected sums.
module tb_adder_operand_loader;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned IN_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n, clear, din_valid, op_ready, result_ack;
    logic [IN_W-1:0]  din;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_valid, result_valid, busy, dropped;
    logic [WIDTH:0]   sum_in, result;
`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
    logic             chain_carry;
`endif

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_v;

    adder_operand_loader #(.WIDTH(WIDTH), .IN_W(IN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .din          (din),
        .din_valid    (din_valid),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .sum_in       (sum_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .busy         (busy),
        .dropped      (dropped)
`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
        ,
        .chain_carry  (chain_carry)
`endif
    );

    // Adder tile model
    assign sum_in = {1'b0, op_a} + {1'b0, op_b};

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chunk(input logic [IN_W-1:0] d);
        din       = d;
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
    endtask

    task automatic send_operand(input logic [WIDTH-1:0] v);
        send_chunk(v[1:0]);
        send_chunk(v[3:2]);
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (result_valid === 1'b1) ok = 1'b1;
            else cycle();
        end
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) exp_v = 'x;
        else exp_v = exp_q.pop_front();
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        cycle();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        checks++; if (op_a !== 4'h0) begin failures++; $display("FAIL reset_op_a got=%h exp=0", op_a); end
        checks++; if (op_b !== 4'h0) begin failures++; $display("FAIL reset_op_b got=%h exp=0", op_b); end
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        checks++; if (result !== 5'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", dropped); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        op_ready = 1'b1;
        exp_q.push_back(5'h11);
        send_operand(4'h9);
        send_operand(4'h8);
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL basic_op_valid got=%b exp=1", op_valid); end
        checks++; if (op_a !== 4'h9 || op_b !== 4'h8) begin failures++; $display("FAIL basic_operands got=%h/%h exp=9/8", op_a, op_b); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", result_valid); end
        cycle();
        pop_exp();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL basic_result_valid got=%b exp=1", result_valid); end
        checks++; if (result !== exp_v) begin failures++; $display("FAIL basic_result got=%h exp=%h", result, exp_v); end
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL basic_op_valid_drop got=%b exp=0", op_valid); end
        do_ack();
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_ack got=%b/%b exp=0/0", result_valid, busy); end
    endtask

    task automatic test_issue_stall();
        bit ok;
        op_ready = 1'b0;
        exp_q.push_back(5'h11);
        send_operand(4'h9);
        send_operand(4'h8);
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL stall_dropped_pre got=%b exp=0", dropped); end
        for (int i = 0; i < 5; i++) begin
            din       = 2'b11;
            din_valid = (i % 2 == 0);
            cycle();
            checks++;
            if ({op_valid, op_a, op_b} !== {1'b1, 4'h9, 4'h8}) begin
                failures++; $display("FAIL stall_hold_%0d got=%b/%h/%h exp=1/9/8", i, op_valid, op_a, op_b);
            end
        end
        din_valid = 1'b0;
        checks++; if (dropped !== 1'b1) begin failures++; $display("FAIL stall_dropped got=%b exp=1", dropped); end
        op_ready = 1'b1;
        cycle();
        op_ready = 1'b0;
        wait_result(ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=0 exp=1"); end
        pop_exp();
        checks++; if (result !== exp_v) begin failures++; $display("FAIL stall_result got=%h exp=%h", result, exp_v); end
        send_chunk(2'b10);
        checks++; if (result_valid !== 1'b1 || result !== 5'h11) begin failures++; $display("FAIL hold_keep got=%b/%h exp=1/11", result_valid, result); end
    endtask

    task automatic test_ack_with_chunk();
        bit ok;
        din        = 2'b11;
        din_valid  = 1'b1;
        result_ack = 1'b1;
        cycle();
        din_valid  = 1'b0;
        result_ack = 1'b0;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL ackchunk_valid got=%b exp=0", result_valid); end
        checks++; if (busy !== 1'b1 || op_valid !== 1'b0) begin failures++; $display("FAIL ackchunk_state got=%b/%b exp=1/0", busy, op_valid); end
        checks++; if (op_a[1:0] !== 2'b11) begin failures++; $display("FAIL ackchunk_a0 got=%b exp=11", op_a[1:0]); end
        exp_q.push_back(5'h0D);
        send_chunk(2'b01);
        send_chunk(2'b10);
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL ackchunk_early got=%b exp=0", op_valid); end
        send_chunk(2'b01);
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL ackchunk_issue got=%b exp=1", op_valid); end
        checks++; if (op_a !== 4'h7 || op_b !== 4'h6) begin failures++; $display("FAIL ackchunk_ops got=%h/%h exp=7/6", op_a, op_b); end
        op_ready = 1'b1;
        wait_result(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ackchunk_timeout got=0 exp=1"); end
        pop_exp();
        checks++; if (result !== exp_v) begin failures++; $display("FAIL ackchunk_result got=%h exp=%h", result, exp_v); end
        do_ack();
    endtask

    task automatic test_clear();
        bit ok;
        op_ready = 1'b0;
        send_operand(4'h5);
        send_chunk(2'b11);
        clear     = 1'b1;
        din       = 2'b10;
        din_valid = 1'b1;
        cycle();
        clear     = 1'b0;
        din_valid = 1'b0;
        checks++; if (busy !== 1'b0 || op_valid !== 1'b0) begin failures++; $display("FAIL clear_idle got=%b/%b exp=0/0", busy, op_valid); end
        checks++; if (result !== 5'h0D || dropped !== 1'b1) begin failures++; $display("FAIL clear_keep got=%h/%b exp=0d/1", result, dropped); end
        exp_q.push_back(5'h10);
        send_operand(4'hF);
        send_operand(4'h1);
        checks++; if (op_valid !== 1'b1 || op_a !== 4'hF || op_b !== 4'h1) begin failures++; $display("FAIL clear_reload got=%b/%h/%h exp=1/f/1", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        wait_result(ok);
        checks++; if (!ok) begin failures++; $display("FAIL clear_timeout got=0 exp=1"); end
        pop_exp();
        checks++; if (result !== exp_v) begin failures++; $display("FAIL clear_result got=%h exp=%h", result, exp_v); end
        do_ack();
        op_ready = 1'b0;
        send_operand(4'h3);
        send_operand(4'h3);
        clear    = 1'b1;
        op_ready = 1'b1;
        cycle();
        clear    = 1'b0;
        op_ready = 1'b0;
        checks++; if (result_valid !== 1'b0 || result !== 5'h10 || busy !== 1'b0) begin
            failures++; $display("FAIL clear_over_ready got=%b/%h/%b exp=0/10/0", result_valid, result, busy);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        send_chunk(2'b11);
        send_chunk(2'b11);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || op_a !== 4'h0 || op_valid !== 1'b0) begin failures++; $display("FAIL areset_load got=%b/%h/%b exp=0/0/0", busy, op_a, op_valid); end
        checks++; if (result !== 5'h00 || dropped !== 1'b0) begin failures++; $display("FAIL areset_load_res got=%h/%b exp=00/0", result, dropped); end
        cycle();
        rst_n    = 1'b1;
        cycle();
        op_ready = 1'b1;
        exp_q.push_back(5'h05);
        send_operand(4'h2);
        send_operand(4'h3);
        wait_result(ok);
        checks++; if (!ok) begin failures++; $display("FAIL areset_timeout got=0 exp=1"); end
        pop_exp();
        checks++; if (result !== exp_v) begin failures++; $display("FAIL areset_pre_result got=%h exp=%h", result, exp_v); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || result !== 5'h00) begin failures++; $display("FAIL areset_hold got=%b/%h exp=0/00", result_valid, result); end
        checks++; if (op_a !== 4'h0 || op_b !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL areset_hold_ops got=%h/%h/%b exp=0/0/0", op_a, op_b, busy); end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [WIDTH-1:0] av[5], bv[5];
        av[0] = 4'hF; bv[0] = 4'hF;
        av[1] = 4'h0; bv[1] = 4'h0;
        av[2] = 4'hA; bv[2] = 4'h5;
        for (int k = 3; k < 5; k++) begin
            av[k] = WIDTH'($urandom_range(0, 15));
            bv[k] = WIDTH'($urandom_range(0, 15));
        end
        op_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({1'b0, av[k]} + {1'b0, bv[k]});
            if (k == 0) send_chunk(av[k][1:0]);
            send_chunk(av[k][3:2]);
            send_operand(bv[k]);
            wait_result(ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout_%0d got=0 exp=1", k); end
            pop_exp();
            checks++; if (result !== exp_v) begin failures++; $display("FAIL b2b_result_%0d got=%h exp=%h", k, result, exp_v); end
            if (k < 4) begin
                din        = av[k+1][1:0];
                din_valid  = 1'b1;
                result_ack = 1'b1;
                cycle();
                din_valid  = 1'b0;
                result_ack = 1'b0;
            end else begin
                do_ack();
            end
        end
        checks++; if (busy !== 1'b0 || dropped !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0/0", busy, dropped); end
    endtask

`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
    task automatic test_chain();
        bit ok;
        op_ready = 1'b1;
        exp_q.push_back(5'h0C);
        send_operand(4'h7);
        send_operand(4'h5);
        wait_result(ok);
        pop_exp();
        checks++; if (!ok || result !== exp_v) begin failures++; $display("FAIL chain_first got=%h exp=%h", result, exp_v); end
        do_ack();
        checks++; if (chain_carry !== 1'b0 || op_a !== 4'hC) begin failures++; $display("FAIL chain_ack1 got=%b/%h exp=0/c", chain_carry, op_a); end
        exp_q.push_back(5'h12);
        send_operand(4'h6);
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL chain_two_chunks got=%b exp=1", op_valid); end
        wait_result(ok);
        pop_exp();
        checks++; if (!ok || result !== exp_v) begin failures++; $display("FAIL chain_second got=%h exp=%h", result, exp_v); end
        do_ack();
        checks++; if (chain_carry !== 1'b1) begin failures++; $display("FAIL chain_carry got=%b exp=1", chain_carry); end
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        checks++; if (chain_carry !== 1'b0) begin failures++; $display("FAIL chain_clear got=%b exp=0", chain_carry); end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        op_ready   = 1'b0;
        result_ack = 1'b0;
        test_reset();
`ifdef ADDER_OPERAND_LOADER_CHAIN_EN
        test_chain();
`else
        test_basic();
        test_issue_stall();
        test_ack_with_chunk();
        test_clear();
        test_async_reset();
        test_back_to_back();
`endif
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
